// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared board constants, click-filter state encoding and square-index helper
package tictactoe_pkg;
    localparam int NUM_SQUARES = 9;
    localparam int SQ_IDX_W = 4;

    typedef enum logic [1:0] {IDLE, CHECK, WAIT_RELEASE, HOLDOFF} cmf_state_t;

    // Binary index of the highest set bit; callers only trust it for one-hot input.
    function automatic logic [SQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_SQUARES-1:0] mat);
        onehot_to_idx = '0;
        for (int i = 0; i < NUM_SQUARES; i++)
            if (mat[i]) onehot_to_idx = SQ_IDX_W'(i);
    endfunction
endpackage

// File: rtl/click_move_filter_if.sv
// click_move_filter_if: mouse/board inputs and move-request outputs between clickedSquare and Maquina
interface click_move_filter_if;
    import tictactoe_pkg::*;
    logic btn_left;
    logic [NUM_SQUARES-1:0] clicked_matrix;
    logic [NUM_SQUARES-1:0] occupied;
    logic enable;
    logic move_valid;
    logic [NUM_SQUARES-1:0] move_onehot;
    logic [SQ_IDX_W-1:0] move_index;
    logic move_reject;
    logic busy;

    modport master (
        output btn_left, clicked_matrix, occupied, enable,
        input  move_valid, move_onehot, move_index, move_reject, busy
    );

    modport slave (
        input  btn_left, clicked_matrix, occupied, enable,
        output move_valid, move_onehot, move_index, move_reject, busy
    );
endinterface

// File: rtl/onehot_validate.sv
// onehot_validate: flags a square matrix with exactly one bit set and gives its index
module onehot_validate
    import tictactoe_pkg::*;
(
    input  logic [NUM_SQUARES-1:0] mat,
    output logic                   is_onehot,
    output logic [SQ_IDX_W-1:0]    idx
);
    assign is_onehot = $countones(mat) == 1;
    assign idx = onehot_to_idx(mat);
endmodule

// File: rtl/click_move_filter.sv
// click_move_filter: turns raw mouse presses into single-cycle accept/reject move pulses
module click_move_filter
    import tictactoe_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 5_000_000,
    parameter int SYNC_STAGES = 2
) (
    input logic clk_100MHz,
    input logic reset,
    click_move_filter_if.slave bus
);
    localparam int CNT_W = HOLDOFF_CYCLES > 0 ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = HOLDOFF_CYCLES > 0 ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

    logic [SYNC_STAGES-1:0] syncChain;
    logic btnS;
    logic btnQ;
    logic btnRise;
    cmf_state_t state;
    logic [CNT_W-1:0] holdCnt;
    logic [NUM_SQUARES-1:0] capMat;
    logic [NUM_SQUARES-1:0] capOcc;
    logic capEn;
    logic capOnehot;
    logic [SQ_IDX_W-1:0] capIdx;
    logic ok;

    assign btnS = syncChain[SYNC_STAGES-1];
    assign btnRise = btnS & ~btnQ;

    onehot_validate u_validate (
        .mat       (capMat),
        .is_onehot (capOnehot),
        .idx       (capIdx)
    );

    assign ok = capEn & capOnehot & ~|(capMat & capOcc);
    assign bus.busy = state != IDLE;

    // Bring the async button level into this clock domain and keep a delayed copy for edge detection.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            syncChain <= '0;
            btnQ <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], bus.btn_left};
            btnQ <= btnS;
        end
    end

    // Press FSM: capture on the edge, decide once, then lock out until release plus holdoff.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state <= WAIT_RELEASE;
            holdCnt <= '0;
            capMat <= '0;
            capOcc <= '0;
            capEn <= 1'b0;
            bus.move_valid <= 1'b0;
            bus.move_reject <= 1'b0;
            bus.move_onehot <= '0;
            bus.move_index <= '0;
        end else begin
            bus.move_valid <= 1'b0;
            bus.move_reject <= 1'b0;
            case (state)
                IDLE: if (btnRise) begin
                    capMat <= bus.clicked_matrix;
                    capOcc <= bus.occupied;
                    capEn <= bus.enable;
                    state <= CHECK;
                end
                CHECK: begin
                    if (ok) begin
                        bus.move_valid <= 1'b1;
                        bus.move_onehot <= capMat;
                        bus.move_index <= capIdx;
                    end else begin
                        bus.move_reject <= 1'b1;
                    end
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: if (!btnS) begin
                    holdCnt <= HOLD_LOAD;
                    state <= HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF;
                end
                HOLDOFF: begin
                    if (btnS) state <= WAIT_RELEASE;
                    else if (holdCnt == '0) state <= IDLE;
                    else holdCnt <= holdCnt - CNT_W'(1);
                end
                default: state <= WAIT_RELEASE;
            endcase
        end
    end
endmodule

// File: tb/tb_click_move_filter.sv
// tb_click_move_filter: directed checks of press filtering, validation, bounce lockout and reset
module tb_click_move_filter;
    logic clk_100MHz = 1'b0;
    logic reset = 1'b1;
    int nPass = 0;
    int nTotal = 0;
    int nValid = 0;
    int nReject = 0;
    int nBoth = 0;
    int nv0;

    click_move_filter_if bus ();

    click_move_filter #(.HOLDOFF_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Tally every pulse cycle so lockout and reset checks can see stray pulses.
    always @(posedge clk_100MHz) begin
        if (bus.move_valid) nValid++;
        if (bus.move_reject) nReject++;
        if (bus.move_valid && bus.move_reject) nBoth++;
    end

    task automatic tick();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_expect(input string tag, input logic expValid, input logic [8:0] expOh,
                                input logic [3:0] expIdx, input logic scramble);
        bus.btn_left = 1'b1;
        repeat (3) tick();
        chk({tag, "/quiet"}, {bus.move_valid, bus.move_reject}, 2'b00);
        if (scramble) begin
            bus.enable = ~bus.enable;
            bus.clicked_matrix = '0;
            bus.occupied = '1;
        end
        tick();
        chk({tag, "/valid"}, bus.move_valid, expValid);
        chk({tag, "/reject"}, bus.move_reject, !expValid);
        chk({tag, "/onehot"}, bus.move_onehot, expOh);
        chk({tag, "/index"}, bus.move_index, expIdx);
        tick();
        chk({tag, "/drop"}, {bus.move_valid, bus.move_reject}, 2'b00);
        bus.btn_left = 1'b0;
        repeat (10) tick();
        chk({tag, "/busy"}, bus.busy, 1'b1);
        tick();
        chk({tag, "/idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.btn_left = 1'b1;
        bus.enable = 1'b0;
        bus.clicked_matrix = '0;
        bus.occupied = '0;
        // 1: button held through reset is never a click
        repeat (2) @(negedge clk_100MHz);
        chk("rst/valid", bus.move_valid, 1'b0);
        chk("rst/reject", bus.move_reject, 1'b0);
        chk("rst/onehot", bus.move_onehot, 9'h000);
        chk("rst/index", bus.move_index, 4'd0);
        chk("rst/busy", bus.busy, 1'b1);
        reset = 1'b0;
        repeat (20) tick();
        chk("t1/held_busy", bus.busy, 1'b1);
        bus.btn_left = 1'b0;
        repeat (10) tick();
        chk("t1/hold_busy", bus.busy, 1'b1);
        tick();
        chk("t1/idle", bus.busy, 1'b0);
        chk("t1/no_pulse", nValid + nReject, 0);
        // 2: valid free square
        bus.enable = 1'b1;
        bus.clicked_matrix = 9'h010;
        press_expect("t2", 1'b1, 9'h010, 4'd4, 1'b0);
        // 3: occupied square
        bus.occupied = 9'h010;
        press_expect("t3", 1'b0, 9'h010, 4'd4, 1'b0);
        // 4: bounce after a valid press
        bus.occupied = 9'h000;
        bus.clicked_matrix = 9'h001;
        nv0 = nValid + nReject;
        bus.btn_left = 1'b1;
        repeat (4) tick();
        chk("t4/valid", bus.move_valid, 1'b1);
        chk("t4/index", bus.move_index, 4'd0);
        bus.btn_left = 1'b0;
        repeat (3) tick();
        bus.btn_left = 1'b1;
        repeat (3) tick();
        chk("t4/bounce_busy", bus.busy, 1'b1);
        bus.btn_left = 1'b0;
        repeat (10) tick();
        chk("t4/hold_busy", bus.busy, 1'b1);
        tick();
        chk("t4/idle", bus.busy, 1'b0);
        chk("t4/one_pulse", nValid + nReject - nv0, 1);
        // 5: off-board, multi-bit, disabled, and enable change after capture
        bus.clicked_matrix = 9'h000;
        press_expect("t5_zero", 1'b0, 9'h001, 4'd0, 1'b0);
        bus.clicked_matrix = 9'h011;
        press_expect("t5_multi", 1'b0, 9'h001, 4'd0, 1'b0);
        bus.enable = 1'b0;
        bus.clicked_matrix = 9'h100;
        press_expect("t5_dis", 1'b0, 9'h001, 4'd0, 1'b0);
        bus.enable = 1'b1;
        press_expect("t5_late", 1'b1, 9'h100, 4'd8, 1'b1);
        bus.enable = 1'b1;
        bus.occupied = 9'h000;
        // 6a: reset during holdoff
        bus.clicked_matrix = 9'h002;
        bus.btn_left = 1'b1;
        repeat (4) tick();
        chk("t6a/valid", bus.move_valid, 1'b1);
        tick();
        bus.btn_left = 1'b0;
        repeat (4) tick();
        chk("t6a/busy", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6a/rst_onehot", bus.move_onehot, 9'h000);
        chk("t6a/rst_index", bus.move_index, 4'd0);
        chk("t6a/rst_busy", bus.busy, 1'b1);
        @(negedge clk_100MHz);
        reset = 1'b0;
        repeat (8) tick();
        chk("t6a/hold_busy", bus.busy, 1'b1);
        tick();
        chk("t6a/idle", bus.busy, 1'b0);
        // 6b: reset during the decision cycle
        bus.clicked_matrix = 9'h004;
        nv0 = nValid + nReject;
        bus.btn_left = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        chk("t6b/rst_pulse", {bus.move_valid, bus.move_reject}, 2'b00);
        chk("t6b/rst_busy", bus.busy, 1'b1);
        @(negedge clk_100MHz);
        reset = 1'b0;
        repeat (6) tick();
        chk("t6b/held_busy", bus.busy, 1'b1);
        bus.btn_left = 1'b0;
        repeat (10) tick();
        chk("t6b/hold_busy", bus.busy, 1'b1);
        tick();
        chk("t6b/idle", bus.busy, 1'b0);
        chk("t6b/no_pulse", nValid + nReject - nv0, 0);
        press_expect("t6_fresh", 1'b1, 9'h004, 4'd2, 1'b0);
        chk("end/valid_count", nValid, 5);
        chk("end/reject_count", nReject, 4);
        chk("end/never_both", nBoth, 0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end
endmodule
